// File: rtl/pc_seq_if.sv
// Fetch-side bundle of the PC sequencer: redirect requests in, fetch address and RAS status out.
// The sequencer side uses the slave modport; the control/fetch side uses master.
interface pc_seq_if #(
  parameter int ADDR_W = 32
);
  // Handshake: pc is meaningful only while pc_valid is 1; fetch_ready=1 on a clock
  // edge means the current pc was consumed, so the sequencer may advance sequentially.
  logic              fetch_ready;
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              call;
  logic [ADDR_W-1:0] call_target;
  logic              ret;
  logic              trap;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_unf;
  logic              misalign;

  modport master (
    output fetch_ready, stall, br_taken, br_target, call, call_target, ret, trap,
    input  pc, pc_valid, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );

  modport slave (
    input  fetch_ready, stall, br_taken, br_target, call, call_target, ret, trap,
    output pc, pc_valid, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with return-address stack; priority trap > ret > call > branch > step.
// Optional target alignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0100)
) (
  input logic     clk,
  input logic     rst_n,
  pc_seq_if.slave bus
);

  localparam int                PTR_W    = $clog2(RAS_DEPTH);
  localparam int                CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  ptr_q;
  logic              ovf_q, unf_q, mis_q;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [ADDR_W-1:0] ras_top;
  logic              br_mis, call_mis, ret_mis;

  logic [ADDR_W-1:0] pc_n;
  logic              do_push, do_pop, do_flush;
  logic              ovf_n, unf_n, mis_n;

  assign pc_inc  = pc_q + STEP_V;
  assign ptr_dec = ptr_q - PTR_W'(1);
  assign ras_top = ras_mem[ptr_dec];

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP_V - ADDR_W'(1);
  assign br_mis   = |(bus.br_target & ALIGN_MASK);
  assign call_mis = |(bus.call_target & ALIGN_MASK);
  assign ret_mis  = |(ras_top & ALIGN_MASK);
`else
  assign br_mis   = 1'b0;
  assign call_mis = 1'b0;
  assign ret_mis  = 1'b0;
`endif

  // The first edge after reset only raises pc_valid; requests are honoured from then on.
  always_comb begin
    pc_n     = pc_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_flush = 1'b0;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    mis_n    = 1'b0;
    if (!valid_q) begin
      pc_n = pc_q;
    end else if (bus.trap) begin
      pc_n     = TRAP_VEC;
      do_flush = 1'b1;
    end else if (bus.ret) begin
      if (cnt_q == '0) begin
        pc_n  = pc_inc;
        unf_n = 1'b1;
      end else begin
        do_pop = 1'b1;
        pc_n   = ret_mis ? TRAP_VEC : ras_top;
        mis_n  = ret_mis;
      end
    end else if (bus.call) begin
      if (call_mis) begin
        pc_n  = TRAP_VEC;
        mis_n = 1'b1;
      end else begin
        do_push = 1'b1;
        pc_n    = bus.call_target;
        ovf_n   = (cnt_q == CNT_FULL);
      end
    end else if (bus.br_taken) begin
      pc_n  = br_mis ? TRAP_VEC : bus.br_target;
      mis_n = br_mis;
    end else if (bus.fetch_ready && !bus.stall) begin
      pc_n = pc_inc;
    end
  end

  // Circular stack: ptr_q is the next free slot, so a push on a full stack lands on the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_n;
      valid_q <= 1'b1;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
      mis_q   <= mis_n;
      if (do_flush) begin
        cnt_q <= '0;
        ptr_q <= '0;
      end else if (do_push) begin
        ptr_q <= ptr_q + PTR_W'(1);
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop) begin
        ptr_q <= ptr_dec;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ptr_q] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = valid_q;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == CNT_FULL);
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
  assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based RAS model predicts every cycle's outputs.
// A second 8-bit instance exercises address wrap-around.
module tb_pc_sequencer;

  localparam int          STEP      = 4;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] TRAP_VEC  = 32'h100;
  localparam int          W         = 38;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_seq_if #(.ADDR_W(32)) bus ();
  pc_seq_if #(.ADDR_W(8))  bus8 ();

  pc_sequencer #(
    .ADDR_W(32), .RESET_VEC(RESET_VEC), .STEP(STEP),
    .RAS_DEPTH(RAS_DEPTH), .TRAP_VEC(TRAP_VEC)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  pc_sequencer #(
    .ADDR_W(8), .RESET_VEC(8'hF8), .STEP(4), .RAS_DEPTH(2), .TRAP_VEC(8'h80)
  ) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] ras_q[$];
  logic [W-1:0] exp_q[$];

  function automatic bit misaligned(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return (t % 32'(STEP)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc    = RESET_VEC;
    m_valid = 1'b0;
    ras_q.delete();
  endtask

  task automatic model_step(input bit fr, st, bt, input logic [31:0] bt_t,
                            input bit c, input logic [31:0] c_t, input bit r, tr);
    bit ovf, unf, mis;
    logic [31:0] t;
    ovf = 0; unf = 0; mis = 0;
    if (!m_valid) begin
      m_valid = 1'b1;
    end else if (tr) begin
      m_pc = TRAP_VEC;
      ras_q.delete();
    end else if (r) begin
      if (ras_q.size() == 0) begin
        m_pc = m_pc + STEP;
        unf  = 1;
      end else begin
        t = ras_q.pop_back();
        mis = misaligned(t);
        m_pc = mis ? TRAP_VEC : t;
      end
    end else if (c) begin
      if (misaligned(c_t)) begin
        mis  = 1;
        m_pc = TRAP_VEC;
      end else begin
        ras_q.push_back(m_pc + STEP);
        if (ras_q.size() > RAS_DEPTH) begin
          void'(ras_q.pop_front());
          ovf = 1;
        end
        m_pc = c_t;
      end
    end else if (bt) begin
      mis  = misaligned(bt_t);
      m_pc = mis ? TRAP_VEC : bt_t;
    end else if (fr && !st) begin
      m_pc = m_pc + STEP;
    end
    exp_q.push_back({m_pc, 1'b1, ras_q.size() == 0, ras_q.size() == RAS_DEPTH, ovf, unf, mis});
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit fr, st, bt, input logic [31:0] bt_t,
                      input bit c, input logic [31:0] c_t, input bit r, tr);
    bus.fetch_ready = fr;
    bus.stall       = st;
    bus.br_taken    = bt;
    bus.br_target   = bt_t;
    bus.call        = c;
    bus.call_target = c_t;
    bus.ret         = r;
    bus.trap        = tr;
    model_step(fr, st, bt, bt_t, c, c_t, r, tr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) t = t + 32'd2;
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] act_v;
  assign act_v = {bus.pc, bus.pc_valid, bus.ras_empty, bus.ras_full,
                  bus.ras_ovf, bus.ras_unf, bus.misalign};

  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_v !== e) begin
        errors++;
        $display("FAIL scoreboard {pc,valid,empty,full,ovf,unf,mis} at %0t: got %h, expected %h",
                 $time, act_v, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [W-1:0] RESET_EXP = {RESET_VEC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    bus.fetch_ready = 0; bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
    bus.call = 0; bus.call_target = '0; bus.ret = 0; bus.trap = 0;
    bus8.fetch_ready = 1; bus8.stall = 0; bus8.br_taken = 0; bus8.br_target = '0;
    bus8.call = 0; bus8.call_target = '0; bus8.ret = 0; bus8.trap = 0;
    model_reset();

    #1 rst_n = 1'b0;
    #2 check("reset_state", act_v, RESET_EXP);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch from reset; 8-bit instance wraps F8 -> FC -> 00
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap8_first", {30'd0, bus8.pc}, {30'd0, 8'hF8});
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap8_second", {30'd0, bus8.pc}, {30'd0, 8'hFC});
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap8_to_zero", {30'd0, bus8.pc}, {30'd0, 8'h00});

    // stall holds, branch during stall still redirects
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h40, 0, 0, 0, 0);
    seq(1);

    // call then return
    step(1, 0, 1, 32'h10, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h200, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);

    // overflow then underflow
    for (int i = 0; i <= RAS_DEPTH; i++) step(1, 0, 0, 0, 1, 32'h1000 + 32'(i * 16), 0, 0);
    for (int i = 0; i <= RAS_DEPTH; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
    seq(1);

    // trap beats everything and flushes
    step(1, 0, 0, 0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 0, 1, 32'h400, 0, 0);
    step(1, 0, 1, 32'h500, 1, 32'h600, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0);

    // ret beats call in the same cycle; 32-bit wrap
    step(1, 0, 0, 0, 1, 32'h700, 0, 0);
    step(1, 0, 0, 0, 1, 32'h800, 1, 0);
    step(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    seq(2);

    // misaligned branch target
    step(1, 0, 1, 32'h42, 0, 0, 0, 0);
    seq(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, rand_tgt(),
           $urandom_range(0, 4) == 0, rand_tgt(),
           $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
    end

    // asynchronous reset mid-run with a non-empty stack
    step(1, 0, 0, 0, 1, 32'h900, 0, 0);
    step(1, 0, 0, 0, 1, 32'hA00, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("midrun_reset", act_v, RESET_EXP);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seq(2);
    step(1, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, rand_tgt(),
           $urandom_range(0, 3) == 0, rand_tgt(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
